// File: rtl/seq_mult_pipe.sv
// seq_mult_pipe: iterative shift-add multiplier, K multiplier bits per cycle, valid/ready on both sides
module seq_mult_pipe #(
  parameter int A_WIDTH = 25,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48,
  parameter int K       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a_in,
  input  logic [B_WIDTH-1:0] b_in,
  input  logic               op_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] result,
  output logic               busy
);
  localparam int ITER = B_WIDTH / K;
  localparam int CW = ITER > 1 ? $clog2(ITER) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [B_WIDTH-1:0] b_sh;
  logic signed [P_WIDTH-1:0] a_sh, acc, pp;
  logic signed [K:0] slice;
  logic sgn, accept, last;
  assign accept = in_valid & in_ready;
  assign last = cnt == CW'(ITER - 1);
  // top slice of a signed multiplier carries the negative MSB weight
  assign slice = {sgn & last & b_sh[K-1], b_sh[K-1:0]};
  assign pp = a_sh * P_WIDTH'(slice);
  assign result = acc;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = accept ? BUSY
             : (state == BUSY && last) ? DONE
             : (state == DONE && out_ready) ? IDLE
             : state;
  end
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
    busy = state == BUSY;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      sgn <= 1'b0;
    end else if (accept) begin
      a_sh <= {{(P_WIDTH-A_WIDTH){op_signed & a_in[A_WIDTH-1]}}, a_in};
      b_sh <= b_in;
      sgn <= op_signed;
      acc <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc + pp;
      a_sh <= a_sh << K;
      b_sh <= b_sh >> K;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_seq_mult_pipe.sv
// tb_seq_mult_pipe: directed and throttled random checks of seq_mult_pipe at K=1, 3 and 9
module tb_seq_mult_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_valid_k = 1'b0, out_ready = 1'b0;
  logic [24:0] a_in = '0;
  logic [17:0] b_in = '0;
  logic op_signed = 1'b0;
  logic in_ready, out_valid, busy;
  logic [47:0] result;
  logic ir3, ov3, busy3, ir9, ov9, busy9;
  logic [47:0] res3, res9;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_mult_pipe #(.K(1)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op_signed(op_signed), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy));
  seq_mult_pipe #(.K(3)) dut3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid_k), .in_ready(ir3),
    .a_in(a_in), .b_in(b_in), .op_signed(op_signed), .out_valid(ov3), .out_ready(1'b1),
    .result(res3), .busy(busy3));
  seq_mult_pipe #(.K(9)) dut9 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid_k), .in_ready(ir9),
    .a_in(a_in), .b_in(b_in), .op_signed(op_signed), .out_valid(ov9), .out_ready(1'b1),
    .result(res9), .busy(busy9));

  function automatic logic [47:0] ref_mul(input logic [24:0] a, input logic [17:0] b, input logic s);
    logic signed [47:0] sa, sb;
    sa = {{23{s & a[24]}}, a};
    sb = {{30{s & b[17]}}, b};
    return sa * sb;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [24:0] a, input logic [17:0] b,
                         input logic s, input logic [47:0] exp);
    int n;
    a_in = a; b_in = b; op_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 48'(in_ready), 48'd1);
    cyc();
    in_valid = 1'b0;
    a_in = '1; b_in = '1; op_signed = ~s;
    n = 0;
    while (!out_valid && n < 100) begin
      cyc();
      n++;
    end
    check({tag, "_latency"}, 48'(n), 48'd18);
    check({tag, "_result"}, result, exp);
    cyc();
    check({tag, "_drop"}, 48'(out_valid), 48'd0);
  endtask

  task automatic stream(input string tag, input int n, input bit thr, input bit b2b);
    logic [47:0] q[$];
    int sent, got, budget;
    bit acc;
    sent = 0; got = 0; budget = 0;
    in_valid = 1'b0;
    while (got < n && budget < n * 60) begin
      out_ready = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!in_valid && sent < n && (!thr || $urandom_range(0, 1) == 1)) begin
        a_in = 25'($urandom);
        b_in = 18'($urandom);
        op_signed = 1'($urandom);
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check({tag, "_dup"}, 48'd1, 48'd0);
        else check({tag, "_result"}, result, q.pop_front());
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        if (b2b && sent > 0) check({tag, "_accept_on_xfer"}, 48'(out_valid && out_ready), 48'd1);
        q.push_back(ref_mul(a_in, b_in, op_signed));
        sent++;
      end
      cyc();
      if (acc) in_valid = 1'b0;
      budget++;
    end
    check({tag, "_count"}, 48'(got), 48'(n));
    check({tag, "_leftover"}, 48'(q.size()), 48'd0);
  endtask

  initial begin
    int n, n1, n3, n9;
    logic [47:0] r1, r3, r9;
    cyc();
    cyc();
    check("rst_in_ready", 48'(in_ready), 48'd1);
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_result", result, 48'd0);
    rst_n = 1'b1;
    cyc();

    a_in = 25'h1FFFFFF; b_in = 18'h3FFFF; op_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (n == 5) check("u_busy", 48'(busy), 48'd1);
      cyc();
      n++;
    end
    check("u_latency", 48'(n), 48'd18);
    check("u_result", result, 48'h07FF_FDFC_0001);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("u_hold_valid", 48'(out_valid), 48'd1);
      check("u_hold_result", result, 48'h07FF_FDFC_0001);
    end
    out_ready = 1'b1;
    cyc();
    check("u_xfer_drop", 48'(out_valid), 48'd0);
    check("u_keep_result", result, 48'h07FF_FDFC_0001);

    run_one("s_m3x5", -25'sd3, 18'sd5, 1'b1, 48'hFFFF_FFFF_FFF1);
    run_one("s_minmin", 25'h1000000, 18'h20000, 1'b1, 48'h0200_0000_0000);
    run_one("u_minmin", 25'h1000000, 18'h20000, 1'b0, 48'h0200_0000_0000);
    run_one("s_m1xm1", 25'h1FFFFFF, 18'h3FFFF, 1'b1, 48'd1);
    run_one("s_m1x7", 25'h1FFFFFF, 18'd7, 1'b1, 48'hFFFF_FFFF_FFF9);
    run_one("zero", 25'd0, 18'd0, 1'b1, 48'd0);

    a_in = 25'd12345; b_in = 18'd6789; op_signed = 1'b0;
    in_valid = 1'b1; in_valid_k = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; in_valid_k = 1'b0;
    n1 = 0; n3 = 0; n9 = 0; r1 = '0; r3 = '0; r9 = '0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (out_valid && n1 == 0) begin n1 = i; r1 = result; end
      if (ov3 && n3 == 0) begin n3 = i; r3 = res3; end
      if (ov9 && n9 == 0) begin n9 = i; r9 = res9; end
    end
    check("k1_latency", 48'(n1), 48'd18);
    check("k3_latency", 48'(n3), 48'd6);
    check("k9_latency", 48'(n9), 48'd2);
    check("k1_result", r1, 48'd83810205);
    check("k3_result", r3, 48'd83810205);
    check("k9_result", r9, 48'd83810205);

    a_in = 25'd100; b_in = 18'd100; op_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (7) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mr_out_valid", 48'(out_valid), 48'd0);
    check("mr_in_ready", 48'(in_ready), 48'd1);
    check("mr_busy", 48'(busy), 48'd0);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (out_valid) n++;
    end
    check("mr_no_output", 48'(n), 48'd0);
    run_one("mr_next", 25'd2, 18'd3, 1'b0, 48'd6);

    stream("b2b", 4, 1'b0, 1'b1);
    stream("rand", 300, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
